fp_acc_seq: RTL and testbench
=============================

Name: fp_acc_seq

Overview:
- Sequential IEEE-754 single-precision accumulator for the ESN datapath (reservoir/readout partial sums).
- Takes a packet of up to LEN float32 terms over a valid/ready stream and returns x0 ± x1 ± … ± x(n-1) on a valid/ready output.
- Reuses the existing `fpu` core as a single shared adder; rounding mode and add/sub are selectable per packet.
- Sticky exception flags are reported alongside the result.

Parameters:
- LEN, 8, maximum terms per packet (≥1); a packet ends after LEN terms or at in_last.
- ADD_LAT, 4, cycles from stable fpu operands to a valid fpu out/flags (≥1).
- CW (localparam), $clog2(LEN+1), width of out_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rmode  in  2  fpu rounding mode; sampled when the first term is accepted.
- sub_mode  in  1  0: add, 1: subtract each later term from the accumulator; sampled when the first term is accepted.
- in_valid  in  1  input term valid.
- in_ready  out  1  block can accept a term.
- in_data  in  32  float32 term.
- in_last  in  1  marks the final term of the packet (qualified by in_valid & in_ready).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  float32 accumulated result.
- out_count  out  CW  number of terms in the packet (1..LEN).
- out_overflow  out  1  sticky OR of fpu overflow over the packet.
- out_inexact  out  1  sticky OR of fpu ine.
- out_nan  out  1  sticky OR of fpu qnan|snan.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; in_ready=0 during the reset cycle, then 1. out_valid=0; out_data=0; out_count=0; all flags=0. Any partial packet is discarded.
- One `fpu` instance:
  - opa = accumulator, opb = latched term.
  - fpu_op = {2'b0, sub_latched}; rmode = rmode_latched.
  - opa/opb/fpu_op/rmode are held stable for the whole ADD state.
- IDLE (in_ready=1): on handshake:
  - acc<=in_data (first term loaded raw, no add); cnt<=1; latch rmode/sub_mode; clear flags.
  - If LEN==1 or in_last → DONE, else → WAIT_IN.
- WAIT_IN (in_ready=1): on handshake, latch in_data and in_last; timer<=ADD_LAT → ADD. If in_valid=0, stay.
- ADD (in_ready=0): timer decrements each cycle. In the cycle with timer==1:
  - acc<=fpu out; OR overflow, ine and qnan|snan into the sticky flags; cnt<=cnt+1.
  - If cnt+1==LEN or the latched last is set → DONE, else → WAIT_IN.
- DONE: out_valid=1; out_data=acc; out_count=cnt; flags as accumulated. in_ready=0.
  - On out_ready → IDLE, out_valid=0 next cycle. Outputs hold stable while out_ready=0.
  - Outputs keep their last values after leaving DONE.
- Timing with in_valid held high:
  - Each additional term takes ADD_LAT+1 cycles.
  - With the first accept at cycle 0, out_valid rises at cycle (n-1)(ADD_LAT+1)+1. Example: LEN=4, ADD_LAT=4 → cycle 16.
  - A single-term packet gives out_valid at cycle 1.
- in_last asserted when cnt would already reach LEN: the packet ends either way; no error.
- in_last in IDLE ends the packet with count 1.
- Reset during ADD or DONE: returns to IDLE, and in-flight fpu results are ignored. The timer restarts on the next ADD, so stale pipeline contents never reach acc.
- No new packet is accepted until the result handshakes (no overlap).

Test Plan:
- LEN=4, ADD_LAT=4, rmode=0, sub=0, terms 0x3F800000, 0x40000000, 0x40400000, 0x40800000 back-to-back → out_data=0x41200000 (10.0), out_count=4, out_valid at cycle 16, flags 0.
- sub_mode=1, terms 0x41200000, 0x3F800000, 0x40000000, 0x40400000 → out_data=0x40800000 (4.0), out_count=4.
- in_last on the 2nd term, 0x3FC00000 + 0x40200000 → out_data=0x40800000, out_count=2, out_valid at cycle 6; a following 4-term packet sums correctly.
- Terms 0x7F7FFFFF + 0x7F7FFFFF (in_last) → out_data=0x7F800000, out_overflow=1; the next packet starts with flags cleared.
- out_ready low 5 cycles in DONE, plus in_valid gaps of 3 cycles in WAIT_IN → out_data/out_count stable, in_ready=0 throughout DONE, result unchanged (10.0).
- rst pulsed in the 2nd ADD cycle of a packet → in_ready=1 on the following cycle, out_valid=0, next packet 1.0+2.0 → 0x40400000.

Source files
------------

// File: rtl/fp_acc_seq.sv
// -----------------------------------------------------------------------------
// fp_acc_seq -- sequential IEEE-754 single-precision accumulator.
//
// Accepts a packet of up to LEN float32 terms on a valid/ready stream and
// returns x0 +/- x1 +/- ... +/- x(n-1) on a valid/ready output. One shared
// fpu adder is reused for every term. Rounding mode and add/sub are captured
// with the first term of each packet.
//
// Ports (fp_acc_seq):
//   clk, rst               clock (rising edge), synchronous active-high reset
//   rmode[1:0], sub_mode   rounding mode / subtract later terms (per packet)
//   in_valid/in_ready      input term handshake
//   in_data[31:0], in_last float32 term, end-of-packet marker
//   out_valid/out_ready    result handshake
//   out_data[31:0]         accumulated result
//   out_count[CW-1:0]      number of terms in the packet
//   out_overflow/out_inexact/out_nan  sticky exception flags of the packet
//
// Ports (fpu, add/sub subset):
//   clk, rmode[1:0], fpu_op[2:0] (0 add, 1 sub, others give qNaN)
//   opa, opb[31:0] operands; out[31:0], overflow, ine, qnan, snan
//   Results appear LAT clock edges after the operands settle.
// -----------------------------------------------------------------------------

module fpu #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] out,
  output logic        overflow,
  output logic        ine,
  output logic        qnan,
  output logic        snan
);

  localparam logic [31:0] QNAN_VAL = 32'h7FC00000;

  // Leading-zero count of a 27-bit value (27 when the value is zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // Round-increment decision from lsb and guard/round/sticky bits.
  // Modes: 0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf.
  function automatic logic rnd_inc(input logic [1:0] rm, input logic sgn,
                                   input logic lsb, input logic [2:0] grs);
    case (rm)
      2'd0:    rnd_inc = grs[2] & (grs[1] | grs[0] | lsb);
      2'd1:    rnd_inc = 1'b0;
      2'd2:    rnd_inc = ~sgn & (|grs);
      default: rnd_inc = sgn & (|grs);
    endcase
  endfunction

  // Overflowed result: modes rounding toward zero saturate to max finite.
  function automatic logic [31:0] sat_ovf(input logic [1:0] rm, input logic sgn);
    if (rm == 2'd1 || (rm == 2'd2 && sgn) || (rm == 2'd3 && !sgn))
      sat_ovf = {sgn, 31'h7F7FFFFF};
    else
      sat_ovf = {sgn, 31'h7F800000};
  endfunction

  logic        w_bsgn, w_swap, w_eff_sub, w_stk, w_inc, w_ovf;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_big_s, w_sml_s;
  logic [30:0] w_big_f, w_sml_f;
  logic [7:0]  w_big_e, w_sml_e, w_d;
  logic [23:0] w_big_m, w_sml_m;
  logic [26:0] w_big_x, w_sml_x, w_nrm;
  logic [27:0] w_sum;
  logic [8:0]  w_er;
  logic [4:0]  w_lz, w_sh;
  logic [30:0] w_pk;
  logic [31:0] w_res_out;
  logic        w_res_ovf, w_res_ine, w_res_qnan, w_res_snan;
  logic [35:0] w_res, w_pipe_out;

  always_comb begin
    w_bsgn  = opb[31] ^ fpu_op[0];
    w_a_nan = (&opa[30:23]) & (|opa[22:0]);
    w_b_nan = (&opb[30:23]) & (|opb[22:0]);
    w_a_inf = (&opa[30:23]) & ~(|opa[22:0]);
    w_b_inf = (&opb[30:23]) & ~(|opb[22:0]);

    // Order operands by magnitude so the aligned difference is never negative.
    w_swap  = opb[30:0] > opa[30:0];
    w_big_s = w_swap ? w_bsgn : opa[31];
    w_sml_s = w_swap ? opa[31] : w_bsgn;
    w_big_f = w_swap ? opb[30:0] : opa[30:0];
    w_sml_f = w_swap ? opa[30:0] : opb[30:0];
    w_big_e = (w_big_f[30:23] == 8'd0) ? 8'd1 : w_big_f[30:23];
    w_sml_e = (w_sml_f[30:23] == 8'd0) ? 8'd1 : w_sml_f[30:23];
    w_big_m = {|w_big_f[30:23], w_big_f[22:0]};
    w_sml_m = {|w_sml_f[30:23], w_sml_f[22:0]};
    w_d     = w_big_e - w_sml_e;

    // Three extra low bits carry guard/round/sticky through alignment.
    w_big_x = {w_big_m, 3'b000};
    if (w_d > 8'd26) begin
      w_sml_x = '0;
      w_stk   = |w_sml_m;
    end else begin
      w_sml_x = {w_sml_m, 3'b000} >> w_d;
      w_stk   = |({w_sml_m, 3'b000} & ~({27{1'b1}} << w_d));
    end
    w_sml_x[0] = w_sml_x[0] | w_stk;

    w_eff_sub = w_big_s ^ w_sml_s;
    w_sum = w_eff_sub ? ({1'b0, w_big_x} - {1'b0, w_sml_x})
                      : ({1'b0, w_big_x} + {1'b0, w_sml_x});

    // Normalise; left shifts stop at exponent 1 so tiny results go subnormal.
    w_lz = lzc27(w_sum[26:0]);
    w_er = {1'b0, w_big_e};
    w_sh = '0;
    if (w_sum[27]) begin
      w_nrm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_er  = w_er + 9'd1;
    end else begin
      w_sh  = (9'(w_lz) < w_er) ? w_lz : 5'(w_er - 9'd1);
      w_nrm = w_sum[26:0] << w_sh;
      w_er  = w_er - 9'(w_sh);
    end

    // Rounding increment on the packed exponent/fraction lets a fraction
    // carry ripple into the exponent (also lifts subnormals to normal).
    w_inc = rnd_inc(rmode, w_big_s, w_nrm[3], w_nrm[2:0]);
    w_pk  = {(w_nrm[26] ? w_er[7:0] : 8'd0), w_nrm[25:3]} + 31'(w_inc);
    w_ovf = (w_er >= 9'd255) || (w_pk[30:23] == 8'hFF);

    w_res_out  = {w_big_s, w_pk};
    w_res_ovf  = 1'b0;
    w_res_ine  = |w_nrm[2:0];
    w_res_qnan = 1'b0;
    w_res_snan = (w_a_nan & ~opa[22]) | (w_b_nan & ~opb[22]);
    if (fpu_op[2:1] != 2'b00 || w_a_nan || w_b_nan ||
        (w_a_inf && w_b_inf && (opa[31] != w_bsgn))) begin
      w_res_out  = QNAN_VAL;
      w_res_qnan = 1'b1;
      w_res_ine  = 1'b0;
    end else if (w_a_inf) begin
      w_res_out = {opa[31], 8'hFF, 23'd0};
      w_res_ine = 1'b0;
    end else if (w_b_inf) begin
      w_res_out = {w_bsgn, 8'hFF, 23'd0};
      w_res_ine = 1'b0;
    end else if (w_sum == 28'd0) begin
      // Exact zero: -0 only for -0 + -0, or a cancellation rounding down.
      w_res_out = {(w_big_s & w_sml_s) | (w_eff_sub & (rmode == 2'd3)), 31'd0};
      w_res_ine = 1'b0;
    end else if (w_ovf) begin
      w_res_out = sat_ovf(rmode, w_big_s);
      w_res_ovf = 1'b1;
      w_res_ine = 1'b1;
    end
  end

  assign w_res = {w_res_out, w_res_ovf, w_res_ine, w_res_qnan, w_res_snan};

  generate
    if (LAT == 0) begin : g_comb
      assign w_pipe_out = w_res;
    end else begin : g_pipe
      logic [35:0] r_pipe [LAT];
      always_ff @(posedge clk) begin
        r_pipe[0] <= w_res;
        for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
      assign w_pipe_out = r_pipe[LAT-1];
    end
  endgenerate

  assign {out, overflow, ine, qnan, snan} = w_pipe_out;

endmodule

module fp_acc_seq #(
  parameter  int LEN     = 8,
  parameter  int ADD_LAT = 4,
  localparam int CW      = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    rmode,
  input  logic          sub_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [CW-1:0] out_count,
  output logic          out_overflow,
  output logic          out_inexact,
  output logic          out_nan
);

  localparam int TW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_ADD, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_acc, r_term;
  logic          r_last, r_sub;
  logic [1:0]    r_rmode;
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic [TW-1:0] r_timer;
  logic          r_ovf, r_ine, r_nan;
  logic [31:0]   r_hold_data;
  logic [CW-1:0] r_hold_cnt;
  logic          r_hold_ovf, r_hold_ine, r_hold_nan;
  logic          w_hs, w_add_done;
  logic [31:0]   w_fpu_out;
  logic          w_fpu_ovf, w_fpu_ine, w_fpu_qnan, w_fpu_snan;

  // Operands stay registered for the whole ADD state; the core adds
  // ADD_LAT-1 register stages so its output is settled on the last ADD cycle.
  fpu #(.LAT(ADD_LAT - 1)) u_fpu (
    .clk      (clk),
    .rmode    (r_rmode),
    .fpu_op   ({2'b00, r_sub}),
    .opa      (r_acc),
    .opb      (r_term),
    .out      (w_fpu_out),
    .overflow (w_fpu_ovf),
    .ine      (w_fpu_ine),
    .qnan     (w_fpu_qnan),
    .snan     (w_fpu_snan)
  );

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_add_done = (r_state == S_ADD) && (r_timer == TW'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:    in_ready = ~rst;
      S_WAIT_IN: in_ready = ~rst;
      S_ADD:     in_ready = 1'b0;
      S_DONE:    out_valid = 1'b1;
      default:   in_ready = 1'b0;
    endcase
    w_hs = in_valid & in_ready;
    case (r_state)
      S_IDLE:
        if (w_hs) w_next = (LEN == 1 || in_last) ? S_DONE : S_WAIT_IN;
      S_WAIT_IN:
        if (w_hs) w_next = S_ADD;
      S_ADD:
        if (w_add_done)
          w_next = (w_cnt_inc == CW'(LEN) || r_last) ? S_DONE : S_WAIT_IN;
      S_DONE:
        if (out_ready) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Packet datapath; the reset state machine decides what gets used, so
  // anything written here during a discarded packet is simply overwritten.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE:
        if (w_hs) begin
          r_acc   <= in_data;
          r_cnt   <= CW'(1);
          r_rmode <= rmode;
          r_sub   <= sub_mode;
          r_ovf   <= 1'b0;
          r_ine   <= 1'b0;
          r_nan   <= 1'b0;
        end
      S_WAIT_IN:
        if (w_hs) begin
          r_term  <= in_data;
          r_last  <= in_last;
          r_timer <= TW'(ADD_LAT);
        end
      S_ADD: begin
        r_timer <= r_timer - 1'b1;
        if (w_add_done) begin
          r_acc <= w_fpu_out;
          r_ovf <= r_ovf | w_fpu_ovf;
          r_ine <= r_ine | w_fpu_ine;
          r_nan <= r_nan | w_fpu_qnan | w_fpu_snan;
          r_cnt <= w_cnt_inc;
        end
      end
      default: ;
    endcase
  end

  // Result copies keep the last packet visible after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_data <= '0;
      r_hold_cnt  <= '0;
      r_hold_ovf  <= 1'b0;
      r_hold_ine  <= 1'b0;
      r_hold_nan  <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_hold_data <= r_acc;
      r_hold_cnt  <= r_cnt;
      r_hold_ovf  <= r_ovf;
      r_hold_ine  <= r_ine;
      r_hold_nan  <= r_nan;
    end
  end

  assign out_data     = (r_state == S_DONE) ? r_acc : r_hold_data;
  assign out_count    = (r_state == S_DONE) ? r_cnt : r_hold_cnt;
  assign out_overflow = (r_state == S_DONE) ? r_ovf : r_hold_ovf;
  assign out_inexact  = (r_state == S_DONE) ? r_ine : r_hold_ine;
  assign out_nan      = (r_state == S_DONE) ? r_nan : r_hold_nan;

endmodule

// File: tb/tb_fp_acc_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_acc_seq -- directed bench for fp_acc_seq (LEN=4, ADD_LAT=4).
// Expected sums are exact hand-computed float32 encodings.
// -----------------------------------------------------------------------------

module tb_fp_acc_seq;

  localparam int LEN     = 4;
  localparam int ADD_LAT = 4;
  localparam int CW      = $clog2(LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    rmode = 2'd0;
  logic          sub_mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [CW-1:0] out_count;
  logic          out_overflow, out_inexact, out_nan;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  fp_acc_seq #(.LEN(LEN), .ADD_LAT(ADD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .rmode        (rmode),
    .sub_mode     (sub_mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact),
    .out_nan      (out_nan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one term; returns the cycle count just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic last, output int t_acc);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t_acc    = -1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        tick();
        t_acc = cyc;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (t_acc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(output int t_out);
    t_out = -1;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin
        t_out = cyc;
        break;
      end
      tick();
    end
    if (t_out < 0) check("out_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_out(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_vld_after_hs"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Back-to-back packet of n terms; in_last on the final term if use_last.
  // Latency counts the accept cycle as cycle 0.
  task automatic run_pkt(input string nm, input logic [1:0] rm, input logic sb,
                         input logic [3:0][31:0] terms, input int n, input logic use_last,
                         input logic [31:0] exp_d, input logic [2:0] exp_flags,
                         input int exp_lat);
    int t_first, t_acc, t_out;
    rmode    = rm;
    sub_mode = sb;
    t_first  = 0;
    for (int k = 0; k < n; k++) begin
      send(terms[k], use_last && (k == n - 1), t_acc);
      if (k == 0) t_first = t_acc;
    end
    rmode    = 2'd0;
    sub_mode = 1'b0;
    wait_out(t_out);
    if (exp_lat >= 0) check({nm, "_lat"}, 32'(t_out - t_first + 1), 32'(exp_lat));
    check({nm, "_data"}, out_data, exp_d);
    check({nm, "_cnt"}, 32'(out_count), 32'(n));
    check({nm, "_flags"}, {29'd0, out_overflow, out_inexact, out_nan}, {29'd0, exp_flags});
    check({nm, "_rdy_done"}, {31'd0, in_ready}, 32'd0);
    take_out(nm);
  endtask

  initial begin
    int t_acc, t_out;
    logic [3:0][31:0] tv;

    // Reset: outputs cleared, in_ready low while rst is high.
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_cnt", 32'(out_count), 32'd0);
    check("rst_flags", {29'd0, out_overflow, out_inexact, out_nan}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready_after", {31'd0, in_ready}, 32'd1);

    // 1+2+3+4 = 10, ends at LEN without in_last.
    tv = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    run_pkt("sum4", 2'd0, 1'b0, tv, 4, 1'b0, 32'h41200000, 3'b000, 16);

    // 10-1-2-3 = 4.
    tv = {32'h40400000, 32'h40000000, 32'h3F800000, 32'h41200000};
    run_pkt("sub4", 2'd0, 1'b1, tv, 4, 1'b0, 32'h40800000, 3'b000, 16);

    // 1.5+2.5 with in_last on term 2.
    tv = {32'h0, 32'h0, 32'h40200000, 32'h3FC00000};
    run_pkt("last2", 2'd0, 1'b0, tv, 2, 1'b1, 32'h40800000, 3'b000, 6);

    // 0.5+0.25+0.125+0.125 = 1.0 right after the short packet.
    tv = {32'h3E000000, 32'h3E000000, 32'h3E800000, 32'h3F000000};
    run_pkt("frac4", 2'd0, 1'b0, tv, 4, 1'b0, 32'h3F800000, 3'b000, 16);

    // in_last in IDLE: single raw term, count 1, valid one cycle later.
    tv = {32'h0, 32'h0, 32'h0, 32'h40490FDB};
    run_pkt("single", 2'd0, 1'b0, tv, 1, 1'b1, 32'h40490FDB, 3'b000, 1);

    // 1 + 2^-24 is a tie: nearest-even keeps 1.0, round-up bumps the lsb.
    tv = {32'h0, 32'h0, 32'h33800000, 32'h3F800000};
    run_pkt("tie_rne", 2'd0, 1'b0, tv, 2, 1'b1, 32'h3F800000, 3'b010, 6);
    run_pkt("tie_up", 2'd2, 1'b0, tv, 2, 1'b1, 32'h3F800001, 3'b010, 6);

    // max+max overflows to +inf; next packet starts with clean flags.
    tv = {32'h0, 32'h0, 32'h7F7FFFFF, 32'h7F7FFFFF};
    run_pkt("ovf", 2'd0, 1'b0, tv, 2, 1'b1, 32'h7F800000, 3'b110, 6);
    tv = {32'h0, 32'h0, 32'h40000000, 32'h3F800000};
    run_pkt("after_ovf", 2'd0, 1'b0, tv, 2, 1'b1, 32'h40400000, 3'b000, 6);

    // Input gaps in WAIT_IN and output backpressure in DONE.
    send(32'h3F800000, 1'b0, t_acc);
    tv = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    for (int k = 1; k < 4; k++) begin
      for (int i = 0; i < 50 && !in_ready; i++) tick();
      for (int g = 0; g < 3; g++) begin
        check("gap_ready", {31'd0, in_ready}, 32'd1);
        tick();
      end
      send(tv[k], 1'b0, t_acc);
    end
    wait_out(t_out);
    in_valid = 1'b1;
    in_data  = 32'h42C80000;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'h41200000);
      check("bp_cnt", 32'(out_count), 32'd4);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    take_out("bp");
    check("hold_data", out_data, 32'h41200000);
    check("hold_cnt", 32'(out_count), 32'd4);

    // Reset in the second ADD cycle discards the packet.
    send(32'h3F800000, 1'b0, t_acc);
    send(32'h40000000, 1'b0, t_acc);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    tv = {32'h0, 32'h0, 32'h40000000, 32'h3F800000};
    run_pkt("post_rst", 2'd0, 1'b0, tv, 2, 1'b1, 32'h40400000, 3'b000, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
